// File: rtl/mic_pkg.sv
// mic_freq_meter shared types and constants.
// Window, scale and width helpers used by top and channels.
package mic_pkg;

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int win_cycles(input int sf, input int wm);
    return int'((longint'(sf) * longint'(wm)) / 1000);
  endfunction

  function automatic int scale_of(input int wm);
    return 1000 / wm;
  endfunction

  // Edge count bound: one accepted edge per holdoff period.
  function automatic int cnt_width(input int wc, input int hold);
    int m;
    m = wc / ((hold > 0) ? hold : 1) + 1;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/mic_edge_chan.sv
// One mic channel: sync, edge detect, holdoff,
// saturating window count, scaling and moving average.
module mic_edge_chan
  import mic_pkg::*;
#(
  parameter int OUT_W     = 16,
  parameter int AVG_DEPTH = 4,
  parameter int HOLDOFF   = 8,
  parameter int CNT_W     = 8,
  parameter int SCALE     = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             run,
  input  logic             term,
  output logic [OUT_W-1:0] freq,
  output logic             ovf
);

  localparam int HW = bits_for(HOLDOFF);
  localparam int SW = bits_for(SCALE + 1);
  localparam int PW = CNT_W + SW + OUT_W;
  localparam int AW = $clog2(AVG_DEPTH);
  localparam int UW = OUT_W + AW;
  localparam int HL = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam logic [PW-1:0] MAXV = PW'({OUT_W{1'b1}});

  logic [2:0]       sync_q, sync_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wovf_q, wovf_d;
  logic [OUT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] hist_q [AVG_DEPTH];
  logic [OUT_W-1:0] hist_d [AVG_DEPTH];
  logic [OUT_W-1:0] hist_n [AVG_DEPTH];

  logic             rise, acc, full, cnt_ovf, sat;
  logic [CNT_W-1:0] cnt_inc;
  logic [PW-1:0]    prod;
  logic [OUT_W-1:0] scaled;
  logic [UW-1:0]    sum_w;

  // Edge accept, count, scale and average datapath.
  always_comb begin
    sync_d  = {sync_q[1:0], sig_in};
    rise    = sync_q[1] & ~sync_q[2];
    acc     = run & rise & (hold_q == '0);
    full    = &cnt_q;
    cnt_ovf = acc & full;
    cnt_inc = cnt_q + CNT_W'(acc & ~full);
    prod    = PW'(cnt_inc) * PW'(SCALE);
    sat     = prod > MAXV;
    scaled  = sat ? {OUT_W{1'b1}} : prod[OUT_W-1:0];
    hist_n[0] = scaled;
    for (int i = 1; i < AVG_DEPTH; i++) hist_n[i] = hist_q[i-1];
    sum_w = '0;
    for (int i = 0; i < AVG_DEPTH; i++) sum_w = sum_w + UW'(hist_n[i]);

    hold_d = hold_q;
    cnt_d  = cnt_q;
    wovf_d = wovf_q;
    freq_d = freq_q;
    ovf_d  = ovf_q;
    hist_d = hist_q;
    if (!run) begin
      hold_d = '0;
      cnt_d  = '0;
      wovf_d = 1'b0;
      for (int i = 0; i < AVG_DEPTH; i++) hist_d[i] = '0;
    end else begin
      if (acc) hold_d = HW'(HL);
      else if (hold_q != '0) hold_d = hold_q - HW'(1);
      if (term) begin
        cnt_d  = '0;
        wovf_d = 1'b0;
        hist_d = hist_n;
        freq_d = OUT_W'(sum_w >> AW);
        ovf_d  = wovf_q | cnt_ovf | sat;
      end else begin
        cnt_d  = cnt_inc;
        wovf_d = wovf_q | cnt_ovf;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hold_q <= '0;
      cnt_q  <= '0;
      wovf_q <= 1'b0;
      freq_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      sync_q <= sync_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
      wovf_q <= wovf_d;
      freq_q <= freq_d;
      ovf_q  <= ovf_d;
      hist_q <= hist_d;
    end
  end

  assign freq = freq_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/mic_freq_meter.sv
// Multi-channel mic frequency meter.
// Gate-window timer and FSM; per-channel logic in mic_edge_chan.
module mic_freq_meter
  import mic_pkg::*;
#(
  parameter int SYS_FREQ  = 100000,
  parameter int WINDOW_MS = 10,
  parameter int NUM_CH    = 2,
  parameter int OUT_W     = 16,
  parameter int AVG_DEPTH = 4,
  parameter int HOLDOFF   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       signal,
  output logic [NUM_CH*OUT_W-1:0] freq,
  output logic                    freq_valid,
  output logic [NUM_CH-1:0]       overflow
);

  localparam int WC    = win_cycles(SYS_FREQ, WINDOW_MS);
  localparam int TW    = bits_for(WC);
  localparam int SCALE = scale_of(WINDOW_MS);
  localparam int CNT_W = cnt_width(WC, HOLDOFF);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          valid_q, valid_d;
  logic          run, term;

  // Window FSM, timer and publish strobe.
  always_comb begin
    run     = (state_q == COUNT) & en;
    term    = run & (timer_q == TW'(WC - 1));
    state_d = state_q;
    timer_d = '0;
    valid_d = term;
    unique case (state_q)
      IDLE:  if (en) state_d = COUNT;
      COUNT: if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (run && !term) timer_d = timer_q + TW'(1);
  end

  // FSM and timer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
    end
  end

  assign freq_valid = valid_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mic_edge_chan #(
      .OUT_W    (OUT_W),
      .AVG_DEPTH(AVG_DEPTH),
      .HOLDOFF  (HOLDOFF),
      .CNT_W    (CNT_W),
      .SCALE    (SCALE)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .sig_in (signal[g]),
      .run    (run),
      .term   (term),
      .freq   (freq[g*OUT_W +: OUT_W]),
      .ovf    (overflow[g])
    );
  end

endmodule
